// File: rtl/bin_dense_pkg.sv
// Shared widths, signed limit helpers and the stage record for the binarized dense MAC.
package bin_dense_pkg;

    localparam int DEF_A_WIDTH   = 20;
    localparam int DEF_B_WIDTH   = 16;
    localparam int DEF_ACC_WIDTH = 48;
    localparam int DEF_P_WIDTH   = DEF_A_WIDTH + DEF_B_WIDTH;

    typedef struct packed {
        logic                          valid;
        logic                          last;
        logic signed [DEF_P_WIDTH-1:0] data;
    } stage_t;

    // Limits are returned at 64 bits; callers size-cast down to their own width.
    function automatic logic signed [63:0] smax(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] smin(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/bin_dense_mac_mul.sv
// Full-precision signed A x B multiplier carrying valid/last through NUM_STAGE registers.
// Latency NUM_STAGE cycles; every register holds while ce is low.
module bin_dense_mac_mul #(
    parameter int A_WIDTH   = 20,
    parameter int B_WIDTH   = 16,
    parameter int NUM_STAGE = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ce,
    input  logic                       in_valid,
    input  logic                       in_last,
    input  logic [A_WIDTH-1:0]         in_a,
    input  logic [B_WIDTH-1:0]         in_b,
    output logic                       out_valid,
    output logic                       out_last,
    output logic [A_WIDTH+B_WIDTH-1:0] out_prod
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    typedef struct packed {
        logic               valid;
        logic               last;
        logic [P_WIDTH-1:0] data;
    } mul_stage_t;

    mul_stage_t                pipe [NUM_STAGE];
    logic signed [P_WIDTH-1:0] a_ext;
    logic signed [P_WIDTH-1:0] b_ext;
    logic        [P_WIDTH-1:0] prod;

    // Sign-extend both operands to the product width so the multiply is exact.
    assign a_ext = P_WIDTH'($signed(in_a));
    assign b_ext = P_WIDTH'($signed(in_b));
    assign prod  = a_ext * b_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STAGE; i++) begin
                pipe[i] <= '0;
            end
        end else if (ce) begin
            pipe[0] <= '{valid: in_valid, last: in_valid & in_last, data: prod};
            for (int i = 1; i < NUM_STAGE; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign out_valid = pipe[NUM_STAGE-1].valid;
    assign out_last  = pipe[NUM_STAGE-1].last;
    assign out_prod  = pipe[NUM_STAGE-1].data;

endmodule

// File: rtl/bin_dense_mac.sv
// Pipelined signed dot-product MAC; BIN_DENSE_MAC_SAT_EN selects saturating accumulation.
// Result NUM_STAGE+1 cycles after the last beat; a held result stalls the whole pipe.
module bin_dense_mac
    import bin_dense_pkg::*;
#(
    parameter int A_WIDTH   = DEF_A_WIDTH,
    parameter int B_WIDTH   = DEF_B_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int NUM_STAGE = 3
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   in_a,
    input  logic [B_WIDTH-1:0]   in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_sat
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;
    localparam int MSB     = ACC_WIDTH - 1;

    logic                 ce;
    logic                 m_valid;
    logic                 m_last;
    logic [P_WIDTH-1:0]   m_prod;
    logic                 acc_vld;
    logic                 acc_last;
    logic [P_WIDTH-1:0]   acc_prod;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] acc_sum;
    logic [ACC_WIDTH-1:0] acc_next;

    assign ce       = !(out_valid && !out_ready);
    assign in_ready = ce;

    bin_dense_mac_mul #(
        .A_WIDTH  (A_WIDTH),
        .B_WIDTH  (B_WIDTH),
        .NUM_STAGE(NUM_STAGE)
    ) u_mul (
        .clk      (ap_clk),
        .rst_n    (ap_rst_n),
        .ce       (ce),
        .in_valid (in_valid),
        .in_last  (in_last),
        .in_a     (in_a),
        .in_b     (in_b),
        .out_valid(m_valid),
        .out_last (m_last),
        .out_prod (m_prod)
    );

    assign prod_ext = ACC_WIDTH'($signed(acc_prod));
    assign acc_sum  = acc + prod_ext;

`ifdef BIN_DENSE_MAC_SAT_EN
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(smax(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(smin(ACC_WIDTH));

    logic ovf;
    logic sat_flag;
    logic sat_q;

    // Same-sign operands producing an opposite-sign sum is the only overflow case.
    assign ovf      = (acc[MSB] == prod_ext[MSB]) && (acc_sum[MSB] != acc[MSB]);
    assign acc_next = !ovf ? acc_sum : (acc[MSB] ? ACC_MIN : ACC_MAX);
    assign out_sat  = sat_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sat_flag <= 1'b0;
            sat_q    <= 1'b0;
        end else if (ce && acc_vld) begin
            if (acc_last) begin
                sat_flag <= 1'b0;
                sat_q    <= sat_flag | ovf;
            end else begin
                sat_flag <= sat_flag | ovf;
            end
        end
    end
`else
    assign acc_next = acc_sum;
    assign out_sat  = 1'b0;
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_vld   <= 1'b0;
            acc_last  <= 1'b0;
            acc_prod  <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (ce) begin
            acc_vld   <= m_valid;
            acc_last  <= m_last;
            acc_prod  <= m_prod;
            out_valid <= acc_vld && acc_last;
            if (acc_vld) begin
                if (acc_last) begin
                    acc      <= '0;
                    out_data <= acc_next;
                end else begin
                    acc <= acc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin_dense_mac.sv
// Directed bench for bin_dense_mac: default 48-bit accumulator plus a 36-bit instance for overflow.
module tb_bin_dense_mac;

    localparam int NUM_STAGE = 3;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        in_valid;
    logic [19:0] in_a;
    logic [15:0] in_b;
    logic        in_last;
    logic        out_ready;

    logic        rdy48, vld48, sat48;
    logic [47:0] data48;
    logic        rdy36, vld36, sat36;
    logic [35:0] data36;

    int errors = 0;
    int checks = 0;

    typedef struct {
        longint d48;
        longint d36;
        logic   s48;
        logic   s36;
    } res_t;

    typedef struct {
        logic [19:0] a;
        logic [15:0] b;
        logic        last;
        longint      exp;
    } vec_t;

    res_t q[$];
    vec_t vecs [10];

    always #5 ap_clk = ~ap_clk;

    bin_dense_mac #(.NUM_STAGE(NUM_STAGE)) dut48 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy48),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(vld48),
        .out_ready(out_ready), .out_data(data48), .out_sat(sat48)
    );

    bin_dense_mac #(.ACC_WIDTH(36), .NUM_STAGE(NUM_STAGE)) dut36 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(rdy36),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(vld36),
        .out_ready(out_ready), .out_data(data36), .out_sat(sat36)
    );

    // Every result that retires is captured here, one entry per handshake.
    always @(negedge ap_clk) begin
        res_t r;
        if (ap_rst_n && vld48 && out_ready) begin
            r.d48 = $signed(data48);
            r.d36 = $signed(data36);
            r.s48 = sat48;
            r.s36 = sat36;
            q.push_back(r);
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out or missing result", name);
    endtask

    // Called at posedge+1; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [19:0] a, input logic [15:0] b, input logic l);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = l;
        forever begin
            @(negedge ap_clk);
            if (rdy48) break;
            n++;
            if (n > 200) begin
                fail("send_accept");
                break;
            end
        end
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!vld48 && n < 50) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        if (!vld48) fail(name);
    endtask

    task automatic get(input string name, output res_t r, output bit ok);
        ok = 1'b0;
        r  = '{0, 0, 1'b0, 1'b0};
        if (q.size() == 0) begin
            fail(name);
        end else begin
            r  = q.pop_front();
            ok = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        bit   ok;
        int   k;

        vecs[0] = '{20'sd3,    -16'sd4,  1'b1, -64'sd12};
        vecs[1] = '{20'sd5,    16'sd2,   1'b0, 64'sd0};
        vecs[2] = '{-20'sd7,   16'sd3,   1'b0, 64'sd0};
        vecs[3] = '{20'sd100,  -16'sd1,  1'b0, 64'sd0};
        vecs[4] = '{20'sd1,    16'sd1,   1'b1, -64'sd110};
        vecs[5] = '{20'h80000, 16'h8000, 1'b1, 64'sd17179869184};
        vecs[6] = '{20'sd2,    16'sd2,   1'b1, 64'sd4};
        vecs[7] = '{-20'sd1,   -16'sd1,  1'b1, 64'sd1};
        vecs[8] = '{20'h7ffff, 16'h7fff, 1'b0, 64'sd0};
        vecs[9] = '{20'h80000, 16'h7fff, 1'b1, -64'sd32767};

        ap_rst_n  = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge ap_clk);
        #1;
        check("rst_in_ready", rdy48, 1);
        check("rst_out_valid", vld48, 0);
        check("rst_out_data", $signed(data48), 0);
        check("rst_out_sat", sat48, 0);
        check("rst_out_sat36", sat36, 0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;

        // Single beat latency.
        send(20'sd3, -16'sd4, 1'b1);
        k = 0;
        while (!vld48 && k < 20) begin
            @(posedge ap_clk);
            #1;
            k++;
        end
        check("lat_cycles", k, NUM_STAGE + 1);
        check("lat_data", $signed(data48), -12);
        check("lat_sat", sat48, 0);
        repeat (3) @(posedge ap_clk);
        #1;
        q.delete();

        // Table of back-to-back beats, results compared in order.
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].last);
        end
        repeat (10) @(posedge ap_clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].last) begin
                get($sformatf("tbl_%0d", i), r, ok);
                if (ok) begin
                    check($sformatf("tbl_data_%0d", i), r.d48, vecs[i].exp);
                    check($sformatf("tbl_sat_%0d", i), r.s48, 0);
                end
            end
        end
        check("tbl_extra", q.size(), 0);

        // Backpressure: result held six cycles, following group survives.
        q.delete();
        out_ready = 1'b0;
        send(20'sd5, 16'sd2, 1'b0);
        send(-20'sd7, 16'sd3, 1'b0);
        send(20'sd100, -16'sd1, 1'b0);
        send(20'sd1, 16'sd1, 1'b1);
        send(20'sd2, 16'sd2, 1'b1);
        wait_valid("stall_wait");
        for (int i = 0; i < 6; i++) begin
            check($sformatf("stall_rdy_%0d", i), rdy48, 0);
            check($sformatf("stall_data_%0d", i), $signed(data48), -110);
            @(posedge ap_clk);
            #1;
        end
        out_ready = 1'b1;
        repeat (10) @(posedge ap_clk);
        #1;
        get("stall_r0", r, ok);
        if (ok) check("stall_r0_data", r.d48, -110);
        get("stall_r1", r, ok);
        if (ok) check("stall_r1_data", r.d48, 4);
        check("stall_extra", q.size(), 0);

        // Overflow at 36 bits: two beats stay just inside, three cross -2^35.
        q.delete();
        send(20'h7ffff, 16'h8000, 1'b0);
        send(20'h7ffff, 16'h8000, 1'b1);
        send(20'h7ffff, 16'h8000, 1'b0);
        send(20'h7ffff, 16'h8000, 1'b0);
        send(20'h7ffff, 16'h8000, 1'b1);
        repeat (10) @(posedge ap_clk);
        #1;
        get("sat2", r, ok);
        if (ok) begin
            check("sat2_d36", r.d36, -64'sd34359672832);
            check("sat2_s36", r.s36, 0);
            check("sat2_d48", r.d48, -64'sd34359672832);
        end
        get("sat3", r, ok);
        if (ok) begin
            check("sat3_d48", r.d48, -64'sd51539509248);
            check("sat3_s48", r.s48, 0);
`ifdef BIN_DENSE_MAC_SAT_EN
            check("sat3_d36", r.d36, -64'sd34359738368);
            check("sat3_s36", r.s36, 1);
`else
            check("sat3_d36", r.d36, 64'sd17179967488);
            check("sat3_s36", r.s36, 0);
`endif
        end

        // Reset mid-group with a result pending.
        q.delete();
        out_ready = 1'b0;
        send(20'sd7, 16'sd7, 1'b1);
        send(20'sd10, 16'sd10, 1'b0);
        send(20'sd10, 16'sd10, 1'b0);
        wait_valid("rst_wait");
        ap_rst_n = 1'b0;
        #2;
        check("mid_rst_valid", vld48, 0);
        check("mid_rst_data", $signed(data48), 0);
        check("mid_rst_ready", rdy48, 1);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        out_ready = 1'b1;
        send(20'sd1, 16'sd1, 1'b1);
        repeat (10) @(posedge ap_clk);
        #1;
        get("post_rst", r, ok);
        if (ok) check("post_rst_data", r.d48, 1);
        check("post_rst_extra", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
